mdu_iter: RTL and testbench

Parameterised multi-cycle multiply/divide unit for the EX stage. It replaces the combinational multiplier and the bare external divider handshake with one sequential engine. The engine covers MULT/MULTU, MADD/MADDU/MSUB/MSUBU and DIV/DIVU.
- EX issues `start` with operands and the forwarded HI/LO.
- EX holds `stallreq` while `busy` is high.
- EX writes `res_hi`/`res_lo` to HI/LO on `done`.
- `cancel` (pipeline flush/exception) aborts the operation in flight.

---
 rtl/mdu_iter.sv | 168 ++++++++++++++++
 tb/tb_mdu_iter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply / multiply-accumulate / divide engine for the EX stage.
// Multiplies go through a retimed product pipe; divides run radix-2 restoring, one bit per cycle.
module mdu_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] opr1,
    input  logic [WIDTH-1:0] opr2,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int unsigned W2   = 2 * WIDTH;
    localparam int unsigned CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned LAST = MUL_LAT - 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q, is_mac_q, is_sub_q, neg_q, s1_q;
    logic [WIDTH-1:0] a_q, ma_q, mb_q, rem_q, quo_q;
    logic [W2-1:0]    acc_q;
    logic [W2-1:0]    pipe_q [MUL_LAT];

    // Operand decode and magnitudes, evaluated against the live inputs at accept
    logic             accept_c, div_op_c, s1_c, s2_c;
    logic [WIDTH-1:0] m1_c, m2_c;
    assign accept_c = start & ~cancel & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign div_op_c = (op[2:1] == 2'b01);
    assign s1_c     = ~op[0] & opr1[WIDTH-1];
    assign s2_c     = ~op[0] & opr2[WIDTH-1];
    assign m1_c     = s1_c ? -opr1 : opr1;
    assign m2_c     = s2_c ? -opr2 : opr2;

    // One restoring-division step
    logic [WIDTH:0] trial_c;
    assign trial_c = {rem_q, quo_q[WIDTH-1]} - {1'b0, mb_q};

    // Final sign correction and accumulate
    logic [W2-1:0]    prod_c, mres_c;
    logic [WIDTH-1:0] dq_c, dr_c;
    assign prod_c = neg_q ? -pipe_q[LAST] : pipe_q[LAST];
    assign mres_c = !is_mac_q ? prod_c : (is_sub_q ? acc_q - prod_c : acc_q + prod_c);
    assign dq_c   = neg_q ? -quo_q : quo_q;
    assign dr_c   = s1_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_c) begin
                    if (!div_op_c)         state_d = S_MUL;
                    else if (opr2 == '0)   state_d = S_FIX;
                    else                   state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (cancel)                        state_d = S_IDLE;
                else if (cnt_q == CW'(MUL_LAT - 1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (cancel)                       state_d = S_IDLE;
                else if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX:   state_d = cancel ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs follow the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == S_MUL) | (state_d == S_DIV) | (state_d == S_FIX);
            done <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            is_mac_q <= 1'b0;
            is_sub_q <= 1'b0;
            neg_q    <= 1'b0;
            s1_q     <= 1'b0;
            a_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            acc_q    <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
        end else begin
            if (accept_c) begin
                cnt_q    <= '0;
                is_div_q <= div_op_c;
                is_mac_q <= op[2];
                is_sub_q <= op[1];
                neg_q    <= s1_c ^ s2_c;
                s1_q     <= s1_c;
                a_q      <= opr1;
                ma_q     <= m1_c;
                mb_q     <= m2_c;
                rem_q    <= '0;
                quo_q    <= m1_c;
                acc_q    <= {acc_hi, acc_lo};
            end else if (state_q == S_MUL) begin
                cnt_q <= CW'(cnt_q + 1'b1);
            end else if (state_q == S_DIV) begin
                cnt_q <= CW'(cnt_q + 1'b1);
                if (!trial_c[WIDTH]) begin
                    rem_q <= trial_c[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            if ((state_q == S_FIX) && !cancel) begin
                if (!is_div_q) begin
                    res_hi <= mres_c[W2-1:WIDTH];
                    res_lo <= mres_c[WIDTH-1:0];
                end else if (mb_q == '0) begin
                    res_hi <= a_q;
                    res_lo <= '1;
                end else begin
                    res_hi <= dr_c;
                    res_lo <= dq_c;
                end
            end
        end
    end

    // Behavioural product, retimed across the pipe by synthesis
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= W2'(ma_q) * W2'(mb_q);
            for (int unsigned i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_iter;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        cancel = 1'b0;
    logic [31:0] opr1 = '0, opr2 = '0, acc_hi = '0, acc_lo = '0;
    logic        busy, done;
    logic [31:0] res_hi, res_lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res = '0;

    mdu_iter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cancel(cancel),
        .opr1(opr1), .opr2(opr2), .acc_hi(acc_hi), .acc_lo(acc_lo),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] ahi, input logic [31:0] alo);
        int sa, sb;
        longint q, r;
        logic [63:0] p, acc;
        sa = a;
        sb = b;
        if (o[2:1] == 2'b01) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o[0]) return {a % b, a / b};
            q = longint'(sa) / longint'(sb);
            r = longint'(sa) % longint'(sb);
            return {r[31:0], q[31:0]};
        end
        if (o[0]) p = {32'd0, a} * {32'd0, b};
        else      p = 64'(longint'(sa) * longint'(sb));
        acc = {ahi, alo};
        if (!o[2])     return p;
        else if (o[1]) return acc - p;
        else           return acc + p;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
        if (o[2:1] != 2'b01) return MUL_LAT + 2;
        if (b == 32'd0)      return 2;
        return WIDTH + 2;
    endfunction

    task automatic scramble();
        op     = 3'($urandom);
        opr1   = $urandom;
        opr2   = $urandom;
        acc_hi = $urandom;
        acc_lo = $urandom;
    endtask

    task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ahi, input logic [31:0] alo);
        op = o; opr1 = a; opr2 = b; acc_hi = ahi; acc_lo = alo;
        start = 1'b1;
    endtask

    // Called at the negedge where start was raised; returns at the negedge showing done
    task automatic finish_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ahi, input logic [31:0] alo,
                             input bit pulse);
        int edges, bc;
        logic [63:0] exp;
        exp = model(o, a, b, ahi, alo);
        @(negedge clk);
        start = 1'b0;
        scramble();
        edges = 1;
        bc = busy ? 1 : 0;
        while (done !== 1'b1 && edges < 200) begin
            start = pulse && (edges == 3);
            if (start) scramble();
            @(negedge clk);
            edges++;
            if (busy) bc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(edges), 64'(exp_lat(o, b)));
        check({tag, " busy_cycles"}, 64'(bc), 64'(exp_lat(o, b) - 1));
        check({tag, " res"}, {res_hi, res_lo}, exp);
        last_res = exp;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ahi, input logic [31:0] alo);
        @(negedge clk);
        drive_start(o, a, b, ahi, alo);
        finish_op(tag, o, a, b, ahi, alo, 1'b0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb, rh, rl;
        bit          quiet;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset res", {res_hi, res_lo}, 64'd0);
        rst = 1'b1;

        run_op("mult_neg3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {62'd0, done, busy}, 64'd0);
        run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        run_op("divu_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        run_op("divu_by0", 3'b011, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
        run_op("div_by0", 3'b010, 32'h8765_4321, 32'd0, 32'd0, 32'd0);
        run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        run_op("msub_2x3", 3'b110, 32'd2, 32'd3, 32'd0, 32'd0);
        run_op("maddu_carry", 3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        run_op("msub_zero_div_code", 3'b110, 32'd7, 32'd0, 32'd1, 32'd2);

        // Cancel mid-divide with a competing start: no done, results held
        @(negedge clk);
        drive_start(3'b010, 32'd1000, 32'd7, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        cancel = 1'b1;
        drive_start(3'b000, 32'd3, 32'd3, 32'd0, 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        start = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel done", 64'(done), 64'd0);
        check("cancel res_held", {res_hi, res_lo}, last_res);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("cancel no_done", 64'(quiet), 64'd1);
        drive_start(3'b010, 32'hFFFF_FC00, 32'd13, 32'd0, 32'd0);
        finish_op("div_after_cancel", 3'b010, 32'hFFFF_FC00, 32'd13, 32'd0, 32'd0, 1'b1);

        // Back-to-back issue in the DONE cycle
        drive_start(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        finish_op("b2b_multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        drive_start(3'b011, 32'd12345, 32'd11, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst busy_done", {62'd0, busy, done}, 64'd0);
        check("async_rst res", {res_hi, res_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Random operations, including divide-by-zero and boundary operands
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            rh = $urandom;
            rl = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 5));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rh, rl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
